// File: rtl/fifo_bit_deserializer.sv
// Read-side consumer of the single-bit async FIFO: pulls bits, assembles WIDTH-bit words and
// presents them on a valid/ready port with one word of output buffering.
module fifo_bit_deserializer #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1,
   parameter int CNT_W     = 16
) (
   input  logic                         r_clk,
   input  logic                         rst,
   input  logic                         empty,
   input  logic                         dataout,
   output logic                         r_en,
   output logic [WIDTH-1:0]             word_out,
   output logic                         word_valid,
   input  logic                         word_ready,
   output logic [$clog2(WIDTH+1)-1:0]   fill_level,
   output logic [CNT_W-1:0]             word_count
);

   localparam int FW = $clog2(WIDTH + 1);
   localparam logic [FW-1:0] FULL = FW'(WIDTH);

   logic [FW-1:0]    req_cnt;
   logic             rd_pend;
   logic [WIDTH-1:0] sh;
   logic [WIDTH-1:0] sh_next;
   logic             transfer;
   logic             handshake;

   // Only issue a read when the bit is guaranteed a slot in the current word.
   assign r_en      = !rst && !empty && (req_cnt < FULL);
   assign transfer  = (fill_level == FULL) && (!word_valid || word_ready);
   assign handshake = word_valid && word_ready;

   generate
      if (MSB_FIRST) begin : g_msb
         assign sh_next = {sh[WIDTH-2:0], dataout};
      end else begin : g_lsb
         assign sh_next = {dataout, sh[WIDTH-1:1]};
      end
   endgenerate

   always_ff @(posedge r_clk or posedge rst) begin
      if (rst) begin
         req_cnt    <= '0;
         rd_pend    <= 1'b0;
         sh         <= '0;
         fill_level <= '0;
         word_out   <= '0;
         word_valid <= 1'b0;
         word_count <= '0;
      end else begin
         rd_pend <= r_en;

         // r_en and transfer are mutually exclusive: transfer needs req_cnt == WIDTH.
         if (transfer) begin
            req_cnt <= '0;
         end else if (r_en) begin
            req_cnt <= req_cnt + FW'(1);
         end

         if (rd_pend) begin
            sh         <= sh_next;
            fill_level <= fill_level + FW'(1);
         end else if (transfer) begin
            fill_level <= '0;
         end

         if (transfer) begin
            word_out   <= sh;
            word_valid <= 1'b1;
         end else if (handshake) begin
            word_valid <= 1'b0;
         end

         if (handshake) begin
            word_count <= word_count + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_fifo_bit_deserializer.sv
// Self-checking bench: FIFO and word assembly modelled with queues; MSB- and LSB-first instances
// share one stimulus stream.
module tb_fifo_bit_deserializer;

   logic        clk = 1'b0;
   logic        rst;
   logic        empty;
   logic        dataout;
   logic        word_ready;
   logic        r_en, r_en_l;
   logic [7:0]  word_out, word_out_l;
   logic        word_valid, word_valid_l;
   logic [3:0]  fill_level, fill_level_l;
   logic [15:0] word_count, word_count_l;

   fifo_bit_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1), .CNT_W(16)) dut (
      .r_clk(clk), .rst(rst), .empty(empty), .dataout(dataout), .r_en(r_en),
      .word_out(word_out), .word_valid(word_valid), .word_ready(word_ready),
      .fill_level(fill_level), .word_count(word_count)
   );

   fifo_bit_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0), .CNT_W(16)) dut_lsb (
      .r_clk(clk), .rst(rst), .empty(empty), .dataout(dataout), .r_en(r_en_l),
      .word_out(word_out_l), .word_valid(word_valid_l), .word_ready(word_ready),
      .fill_level(fill_level_l), .word_count(word_count_l)
   );

   always #5 clk = ~clk;

   bit         src_q[$];
   bit         popped[$];
   logic [7:0] got_m[$];
   logic [7:0] got_l[$];
   bit         hold_empty;
   int         n_cmp, n_err;
   int         cyc, rcycles, last_fire_cyc, valid_cyc;

   // Expected word k from the bits the FIFO handed out, by plain positional weighting.
   function automatic logic [7:0] pack(int k, bit msb);
      logic [7:0] w = '0;
      for (int i = 0; i < 8; i++) begin
         if (popped[k*8+i]) w = w | (8'd1 << (msb ? 7 - i : i));
      end
      return w;
   endfunction

   // One clock: FIFO model pops on a sampled read, presents the bit one cycle later.
   task automatic step();
      bit fire;
      @(negedge clk);
      fire = r_en && !empty;
      if (fire) begin
         rcycles++;
         last_fire_cyc = cyc;
      end
      if (word_valid && valid_cyc < 0) valid_cyc = cyc;
      if (word_valid && word_ready) begin
         got_m.push_back(word_out);
         got_l.push_back(word_out_l);
      end
      @(posedge clk);
      #1;
      cyc++;
      if (fire) begin
         dataout = src_q.pop_front();
         popped.push_back(dataout);
      end else begin
         dataout = 1'($urandom);
      end
      empty = hold_empty || (src_q.size() == 0);
   endtask

   task automatic load_bits(logic [7:0] v, int n);
      for (int i = 0; i < n; i++) src_q.push_back(v[7-i]);
      empty = hold_empty || (src_q.size() == 0);
   endtask

   task automatic load_random(int n);
      for (int i = 0; i < n; i++) src_q.push_back(1'($urandom));
      empty = hold_empty || (src_q.size() == 0);
   endtask

   task automatic clear_model();
      popped.delete();
      got_m.delete();
      got_l.delete();
      rcycles   = 0;
      valid_cyc = -1;
   endtask

   task automatic run_until_words(int n, int bound, string name);
      int k = 0;
      while (got_m.size() < n && k < bound) begin
         step();
         k++;
      end
      if (got_m.size() < n) begin
         n_cmp++; n_err++;
         $display("FAIL %s: timeout, words seen %0d, required %0d", name, got_m.size(), n);
      end
   endtask

   task automatic test_reset();
      clear_model();
      rst = 1'b1; word_ready = 1'b0; hold_empty = 1'b0;
      load_random(8);
      step(); step();
      n_cmp++; if (r_en !== 1'b0) begin n_err++; $display("FAIL reset_ren: got %b want 0", r_en); end
      n_cmp++; if (word_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", word_valid); end
      n_cmp++; if (word_count !== 16'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", word_count); end
      n_cmp++; if (fill_level !== 4'd0) begin n_err++; $display("FAIL reset_fill: got %0d want 0", fill_level); end
      n_cmp++; if (word_out !== 8'h00) begin n_err++; $display("FAIL reset_word: got %h want 00", word_out); end
      rst = 1'b0;
      #1;
      n_cmp++; if (r_en !== 1'b1) begin n_err++; $display("FAIL release_ren: got %b want 1", r_en); end
      word_ready = 1'b1;
      run_until_words(1, 50, "reset_word_timeout");
      if (got_m.size() >= 1) begin
         n_cmp++; if (got_m[0] !== pack(0, 1'b1)) begin n_err++; $display("FAIL first_word: got %h want %h", got_m[0], pack(0, 1'b1)); end
      end
      step();
   endtask

   task automatic test_single_word();
      logic [15:0] wc0;
      clear_model();
      wc0 = word_count;
      word_ready = 1'b1;
      load_bits(8'hB2, 8);
      run_until_words(1, 50, "single_timeout");
      step(); step(); step();
      n_cmp++; if (rcycles !== 8) begin n_err++; $display("FAIL single_ren_cycles: got %0d want 8", rcycles); end
      n_cmp++; if (valid_cyc - last_fire_cyc !== 3) begin n_err++; $display("FAIL single_latency: got %0d want 3", valid_cyc - last_fire_cyc); end
      if (got_m.size() >= 1) begin
         n_cmp++; if (got_m[0] !== 8'hB2) begin n_err++; $display("FAIL single_msb: got %h want b2", got_m[0]); end
         n_cmp++; if (got_l[0] !== 8'h4D) begin n_err++; $display("FAIL bit_order_lsb: got %h want 4d", got_l[0]); end
      end
      n_cmp++; if (word_count !== wc0 + 16'd1) begin n_err++; $display("FAIL single_count: got %0d want %0d", word_count, wc0 + 16'd1); end
   endtask

   task automatic test_backpressure();
      logic [15:0] wc0;
      clear_model();
      wc0 = word_count;
      word_ready = 1'b0;
      load_random(24);
      for (int i = 0; i < 40; i++) step();
      n_cmp++; if (word_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid: got %b want 1", word_valid); end
      n_cmp++; if (word_out !== pack(0, 1'b1)) begin n_err++; $display("FAIL bp_hold_word: got %h want %h", word_out, pack(0, 1'b1)); end
      n_cmp++; if (fill_level !== 4'd8) begin n_err++; $display("FAIL bp_fill: got %0d want 8", fill_level); end
      n_cmp++; if (r_en !== 1'b0) begin n_err++; $display("FAIL bp_ren: got %b want 0", r_en); end
      n_cmp++; if (rcycles !== 16) begin n_err++; $display("FAIL bp_reads: got %0d want 16", rcycles); end
      word_ready = 1'b1;
      run_until_words(3, 80, "bp_timeout");
      step();
      for (int k = 0; k < 3 && k < got_m.size(); k++) begin
         n_cmp++; if (got_m[k] !== pack(k, 1'b1)) begin n_err++; $display("FAIL bp_word%0d: got %h want %h", k, got_m[k], pack(k, 1'b1)); end
         n_cmp++; if (got_l[k] !== pack(k, 1'b0)) begin n_err++; $display("FAIL bp_lsb_word%0d: got %h want %h", k, got_l[k], pack(k, 1'b0)); end
      end
      n_cmp++; if (word_count !== wc0 + 16'd3) begin n_err++; $display("FAIL bp_count: got %0d want %0d", word_count, wc0 + 16'd3); end
      n_cmp++; if (rcycles !== 24) begin n_err++; $display("FAIL bp_total_reads: got %0d want 24", rcycles); end
   endtask

   task automatic test_starvation();
      clear_model();
      word_ready = 1'b1;
      load_random(3);
      for (int i = 0; i < 12; i++) step();
      n_cmp++; if (r_en !== 1'b0) begin n_err++; $display("FAIL starve_ren: got %b want 0", r_en); end
      n_cmp++; if (fill_level !== 4'd3) begin n_err++; $display("FAIL starve_fill: got %0d want 3", fill_level); end
      load_random(5);
      run_until_words(1, 50, "starve_timeout");
      if (got_m.size() >= 1) begin
         n_cmp++; if (got_m[0] !== pack(0, 1'b1)) begin n_err++; $display("FAIL starve_word: got %h want %h", got_m[0], pack(0, 1'b1)); end
      end
      step();
   endtask

   task automatic test_reset_mid_word();
      int k = 0;
      clear_model();
      word_ready = 1'b1;
      load_random(8);
      while (fill_level != 4'd5 && k < 40) begin
         step();
         k++;
      end
      rst = 1'b1;
      step();
      n_cmp++; if (fill_level !== 4'd0) begin n_err++; $display("FAIL midrst_fill: got %0d want 0", fill_level); end
      n_cmp++; if (word_valid !== 1'b0) begin n_err++; $display("FAIL midrst_valid: got %b want 0", word_valid); end
      src_q.delete();
      clear_model();
      load_random(8);
      rst = 1'b0;
      run_until_words(1, 50, "midrst_timeout");
      if (got_m.size() >= 1) begin
         n_cmp++; if (got_m[0] !== pack(0, 1'b1)) begin n_err++; $display("FAIL midrst_word: got %h want %h", got_m[0], pack(0, 1'b1)); end
         n_cmp++; if (got_l[0] !== pack(0, 1'b0)) begin n_err++; $display("FAIL midrst_lsb: got %h want %h", got_l[0], pack(0, 1'b0)); end
      end
      step();
   endtask

   task automatic test_random_stream();
      bit         stalled;
      logic [7:0] prev;
      int         k = 0;
      clear_model();
      load_random(64);
      while (got_m.size() < 8 && k < 3000) begin
         hold_empty = ($urandom_range(3) == 0);
         word_ready = 1'($urandom);
         stalled = word_valid && !word_ready;
         prev    = word_out;
         step();
         k++;
         if (stalled) begin
            n_cmp++;
            if (word_valid !== 1'b1 || word_out !== prev) begin
               n_err++;
               $display("FAIL stall_stable: got valid %b word %h want valid 1 word %h", word_valid, word_out, prev);
            end
         end
      end
      hold_empty = 1'b0;
      word_ready = 1'b1;
      if (got_m.size() < 8) begin
         n_cmp++; n_err++;
         $display("FAIL rand_timeout: words %0d want 8", got_m.size());
      end
      for (int i = 0; i < got_m.size(); i++) begin
         n_cmp++; if (got_m[i] !== pack(i, 1'b1)) begin n_err++; $display("FAIL rand_word%0d: got %h want %h", i, got_m[i], pack(i, 1'b1)); end
         n_cmp++; if (got_l[i] !== pack(i, 1'b0)) begin n_err++; $display("FAIL rand_lsb%0d: got %h want %h", i, got_l[i], pack(i, 1'b0)); end
      end
   endtask

   initial begin
      n_cmp = 0; n_err = 0; cyc = 0; last_fire_cyc = 0;
      rst = 1'b1; empty = 1'b1; dataout = 1'b0; word_ready = 1'b0; hold_empty = 1'b0;
      test_reset();
      test_single_word();
      test_backpressure();
      test_starvation();
      test_reset_mid_word();
      test_random_stream();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
